frv_dmem_responder: RTL

- Responder end of the core data-memory interface: accepts dmem_req/dmem_gnt requests from the core LSU and returns responses on the dmem_recv/dmem_ack/dmem_error/dmem_rdata channel.
- Contains a word-addressed SRAM model, a programmable-latency response pipeline and a credit-limited response FIFO.
- Used as the data memory in core-level integration and formal benches.

---
 rtl/frv_dmem_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/frv_dmem_responder.sv
// frv_dmem_responder: responder side of the core data-memory interface.
// Holds a word-addressed SRAM model, a LATENCY-stage response pipeline and an
// in-order response FIFO whose depth equals the outstanding-request credit.
module frv_dmem_responder #(
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int          MEM_SIZE    = 4096,
  parameter int          LATENCY     = 1,
  parameter int          OUTSTANDING = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_addr,
  output logic        dmem_gnt,
  output logic        dmem_recv,
  input  logic        dmem_ack,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata
);

  localparam int WORDS = MEM_SIZE / 4;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = $clog2(OUTSTANDING + 1);
  localparam int PW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  logic              accept;
  logic              acc_err;
  logic              in_range;
  logic [32:0]       diff;
  logic [IW-1:0]     word_idx;
  logic [31:0]       acc_rdata;
  logic [31:0]       mem [WORDS];

  logic              push_v;
  logic              push_err;
  logic [31:0]       push_rdata;
  logic              pop;

  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              fifo_err_q  [OUTSTANDING];
  logic [31:0]       fifo_data_q [OUTSTANDING];

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Grant from the credit count, window/alignment check and read-word select.
  always_comb begin
    dmem_gnt  = dmem_req && (count_q < CW'(OUTSTANDING));
    accept    = dmem_gnt;
    diff      = {1'b0, dmem_addr} - {1'b0, MEM_BASE};
    in_range  = !diff[32] && (diff[31:0] < 32'(MEM_SIZE));
    acc_err   = (dmem_addr[1:0] != 2'b00) || !in_range;
    word_idx  = diff[IW+1:2];
    acc_rdata = (acc_err || dmem_wen) ? 32'h0 : mem[word_idx];
  end

  // SRAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge g_clk) begin
    if (accept && dmem_wen && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_strb[i]) begin
          mem[word_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response pipeline: the accept cycle counts as the first stage, so
  // LATENCY-1 register stages sit between acceptance and the FIFO push.
  if (LATENCY == 1) begin : g_direct
    assign push_v     = accept;
    assign push_err   = acc_err;
    assign push_rdata = acc_rdata;
  end else begin : g_pipe
    localparam int ST = LATENCY - 1;
    logic [ST-1:0] pv_q, pv_d;
    logic [ST-1:0] pe_q, pe_d;
    logic [31:0]   pd_q [ST];
    logic [31:0]   pd_d [ST];

    // Shift the accepted response tuple one stage per cycle.
    always_comb begin
      pv_d    = '0;
      pe_d    = '0;
      pv_d[0] = accept;
      pe_d[0] = acc_err;
      pd_d[0] = acc_rdata;
      for (int i = 1; i < ST; i++) begin
        pv_d[i] = pv_q[i-1];
        pe_d[i] = pe_q[i-1];
        pd_d[i] = pd_q[i-1];
      end
    end

    // Pipeline registers; reset drops every in-flight response.
    always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
        pv_q <= '0;
        pe_q <= '0;
        for (int i = 0; i < ST; i++) begin
          pd_q[i] <= '0;
        end
      end else begin
        pv_q <= pv_d;
        pe_q <= pe_d;
        for (int i = 0; i < ST; i++) begin
          pd_q[i] <= pd_d[i];
        end
      end
    end

    assign push_v     = pv_q[ST-1];
    assign push_err   = pe_q[ST-1];
    assign push_rdata = pd_q[ST-1];
  end

  // Credit count, FIFO bookkeeping and the head-of-FIFO response outputs.
  always_comb begin
    dmem_recv = (fcnt_q != '0);
    pop       = dmem_recv && dmem_ack;

    count_d = count_q;
    if (accept && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!accept && pop) begin
      count_d = count_q - CW'(1);
    end

    fcnt_d = fcnt_q;
    if (push_v && !pop) begin
      fcnt_d = fcnt_q + CW'(1);
    end else if (!push_v && pop) begin
      fcnt_d = fcnt_q - CW'(1);
    end

    rd_ptr_d = pop    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_v ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    dmem_error = dmem_recv ? fifo_err_q[rd_ptr_q]  : 1'b0;
    dmem_rdata = dmem_recv ? fifo_data_q[rd_ptr_q] : 32'h0;
  end

  // Credit and FIFO state registers; push writes the tail entry.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      count_q  <= '0;
      fcnt_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        fifo_err_q[i]  <= 1'b0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      fcnt_q   <= fcnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push_v) begin
        fifo_err_q[wr_ptr_q]  <= push_err;
        fifo_data_q[wr_ptr_q] <= push_rdata;
      end
    end
  end

endmodule
